// File: rtl/ebpc_pkg.sv
// Shared EBPC decoder constants, symbol length type and its bit-count helper.
package ebpc_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned LOG_DATA_W = $clog2(DATA_W);
  localparam int unsigned BLOCK_SIZE = 8;

  // Encoded symbol length: stored value is the bit count minus one (1..DATA_W).
  typedef logic [LOG_DATA_W-1:0] symb_len_t;

  function automatic logic [LOG_DATA_W:0] symb_len_bits(symb_len_t len);
    return {1'b0, len} + (LOG_DATA_W+1)'(1);
  endfunction

endpackage

// File: rtl/symbol_unpacker_if.sv
// Stream-in and window/consume bundle between the bitstream source, unpacker and symbol expander.
interface symbol_unpacker_if;
  import ebpc_pkg::*;

  logic [DATA_W-1:0]     data_i;
  logic                  vld_i;
  logic                  last_i;
  logic                  rdy_o;
  logic [DATA_W-1:0]     window_o;
  logic                  win_vld_o;
  logic [LOG_DATA_W:0]   shift_i;
  logic                  shift_vld_i;
  logic                  flush_i;
  logic [LOG_DATA_W+1:0] fill_o;
  logic                  err_o;

  modport master (
    output data_i, vld_i, last_i, shift_i, shift_vld_i, flush_i,
    input  rdy_o, window_o, win_vld_o, fill_o, err_o
  );

  modport slave (
    input  data_i, vld_i, last_i, shift_i, shift_vld_i, flush_i,
    output rdy_o, window_o, win_vld_o, fill_o, err_o
  );

endinterface

// File: rtl/unpack_shifter.sv
// Combinational 2*DATA_W barrel shifter: left-shift of the buffer plus word insertion at an offset.
module unpack_shifter
  import ebpc_pkg::*;
(
  input  logic [2*DATA_W-1:0]   cur_bits,
  input  logic [LOG_DATA_W:0]   shamt,
  input  logic                  clear,
  input  logic [DATA_W-1:0]     word,
  input  logic                  ins_en,
  input  logic [LOG_DATA_W+1:0] ins_off,
  output logic [2*DATA_W-1:0]   next_bits
);

  localparam int unsigned BUF_W   = 2 * DATA_W;
  localparam int unsigned L_STAGE = LOG_DATA_W + 1;
  localparam int unsigned R_STAGE = LOG_DATA_W + 2;

  logic [BUF_W-1:0] left_stage  [L_STAGE+1];
  logic [BUF_W-1:0] right_stage [R_STAGE+1];

  assign left_stage[0]  = cur_bits;
  assign right_stage[0] = ins_en ? {word, {DATA_W{1'b0}}} : '0;

  genvar gi;
  generate
    for (gi = 0; gi < L_STAGE; gi++) begin : g_left
      assign left_stage[gi+1] = shamt[gi] ? (left_stage[gi] << (1 << gi)) : left_stage[gi];
    end
    // The new word starts MSB-aligned and slides down below the surviving bits.
    for (gi = 0; gi < R_STAGE; gi++) begin : g_right
      assign right_stage[gi+1] = ins_off[gi] ? (right_stage[gi] >> (1 << gi)) : right_stage[gi];
    end
  endgenerate

  assign next_bits = (clear ? '0 : left_stage[L_STAGE]) | right_stage[R_STAGE];

endmodule

// File: rtl/symbol_unpacker.sv
// Bit-level unpacker feeding the EBPC symbol expander with an MSB-aligned look-ahead window.
// Build option EBPC_UNPACK_ERR_CHECK_EN: sticky over-consume flag on err_o and a shift-range assertion.
module symbol_unpacker
  import ebpc_pkg::*;
(
  input logic              clk_i,
  input logic              rst_ni,
  symbol_unpacker_if.slave bus
);

  localparam int unsigned BUF_W  = 2 * DATA_W;
  localparam int unsigned FILL_W = LOG_DATA_W + 2;

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t              state_reg, state_next;
  logic [BUF_W-1:0]    bits_reg, bits_next, shifted_bits;
  logic [FILL_W-1:0]   fill_reg, fill_next, fill_after;
  logic [FILL_W-1:0]   shift_req_ext, shift_amt_ext;
  logic [LOG_DATA_W:0] shift_amt;
  logic                win_vld_reg, win_vld_next;
  logic                rdy, load, do_shift, over;

  assign rdy           = (fill_reg <= FILL_W'(DATA_W)) && (state_reg == RUN) && !bus.flush_i;
  assign load          = bus.vld_i && rdy;
  assign do_shift      = bus.shift_vld_i && win_vld_reg;
  assign shift_req_ext = FILL_W'(bus.shift_i);
  assign over          = do_shift && (shift_req_ext > fill_reg);
  assign shift_amt     = do_shift ? bus.shift_i : '0;
  assign shift_amt_ext = FILL_W'(shift_amt);
  // Over-consume empties the buffer instead of wrapping the fill count.
  assign fill_after    = over ? '0 : (fill_reg - shift_amt_ext);

  unpack_shifter u_shifter (
    .cur_bits  (bits_reg),
    .shamt     (shift_amt),
    .clear     (over),
    .word      (bus.data_i),
    .ins_en    (load),
    .ins_off   (fill_after),
    .next_bits (shifted_bits)
  );

  always_comb begin
    state_next = state_reg;
    bits_next  = shifted_bits;
    fill_next  = fill_after + (load ? FILL_W'(DATA_W) : '0);
    if (bus.flush_i) begin
      state_next = RUN;
      bits_next  = '0;
      fill_next  = '0;
    end else begin
      case (state_reg)
        RUN:     if (load && bus.last_i) state_next = DRAIN;
        DRAIN:   if (do_shift && (fill_next == '0)) state_next = RUN;
        default: state_next = RUN;
      endcase
    end
    win_vld_next = (fill_next >= FILL_W'(DATA_W)) ||
                   ((state_next == DRAIN) && (fill_next != '0));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= RUN;
      bits_reg    <= '0;
      fill_reg    <= '0;
      win_vld_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bits_reg    <= bits_next;
      fill_reg    <= fill_next;
      win_vld_reg <= win_vld_next;
    end
  end

  assign bus.rdy_o     = rdy;
  assign bus.window_o  = bits_reg[BUF_W-1 -: DATA_W];
  assign bus.win_vld_o = win_vld_reg;
  assign bus.fill_o    = fill_reg;

`ifdef EBPC_UNPACK_ERR_CHECK_EN
  logic err_reg;

  // A flush cancels the shift, so it cannot raise the error either.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_reg <= 1'b0;
    end else if (over && !bus.flush_i) begin
      err_reg <= 1'b1;
    end
  end

  assign bus.err_o = err_reg;

  a_shift_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.shift_vld_i |-> (bus.shift_i <= (LOG_DATA_W+1)'(DATA_W)));
`else
  assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_symbol_unpacker.sv
// Directed and model-based checks of symbol_unpacker with DATA_W=8.
module tb_symbol_unpacker;
  import ebpc_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  symbol_unpacker_if u_if ();

  symbol_unpacker u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (u_if)
  );

  always #5 clk = ~clk;

  task automatic idle();
    u_if.data_i      = '0;
    u_if.vld_i       = 1'b0;
    u_if.last_i      = 1'b0;
    u_if.shift_i     = '0;
    u_if.shift_vld_i = 1'b0;
    u_if.flush_i     = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_all();
    idle();
    u_if.flush_i = 1'b1;
    step();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    step();
    step();
    checks++; if (u_if.fill_o !== 5'd0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", u_if.fill_o); end
    checks++; if (u_if.window_o !== 8'h00) begin errors++; $display("FAIL reset_window: got %h expected 00", u_if.window_o); end
    checks++; if (u_if.win_vld_o !== 1'b0) begin errors++; $display("FAIL reset_win_vld: got %b expected 0", u_if.win_vld_o); end
    checks++; if (u_if.rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", u_if.rdy_o); end
    checks++; if (u_if.err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", u_if.err_o); end
    rst_n = 1'b1;
    step();
    $display("reset: fill %0d window %h rdy %b", u_if.fill_o, u_if.window_o, u_if.rdy_o);
  endtask

  task automatic test_load_shift8();
    u_if.data_i = 8'hA5; u_if.vld_i = 1'b1;
    #1;
    checks++; if (u_if.rdy_o !== 1'b1) begin errors++; $display("FAIL load_rdy: got %b expected 1", u_if.rdy_o); end
    step();
    checks++; if (u_if.window_o !== 8'hA5) begin errors++; $display("FAIL load_window_a5: got %h expected a5", u_if.window_o); end
    checks++; if (u_if.fill_o !== 5'd8) begin errors++; $display("FAIL load_fill_8: got %0d expected 8", u_if.fill_o); end
    checks++; if (u_if.win_vld_o !== 1'b1) begin errors++; $display("FAIL load_win_vld: got %b expected 1", u_if.win_vld_o); end
    $display("load a5: window %h fill %0d", u_if.window_o, u_if.fill_o);
    u_if.data_i = 8'h3C; u_if.shift_vld_i = 1'b1; u_if.shift_i = 4'd8;
    step();
    checks++; if (u_if.window_o !== 8'h3C) begin errors++; $display("FAIL shift8_window_3c: got %h expected 3c", u_if.window_o); end
    checks++; if (u_if.fill_o !== 5'd8) begin errors++; $display("FAIL shift8_fill: got %0d expected 8", u_if.fill_o); end
    $display("load 3c + shift 8: window %h fill %0d", u_if.window_o, u_if.fill_o);
    u_if.vld_i = 1'b0;
    step();
    checks++; if (u_if.fill_o !== 5'd0) begin errors++; $display("FAIL shift8_empty_fill: got %0d expected 0", u_if.fill_o); end
    checks++; if (u_if.win_vld_o !== 1'b0) begin errors++; $display("FAIL shift8_empty_win_vld: got %b expected 0", u_if.win_vld_o); end
    idle();
  endtask

  task automatic test_partial_shift();
    u_if.data_i = 8'hA5; u_if.vld_i = 1'b1;
    step();
    u_if.data_i = 8'h3C;
    step();
    checks++; if (u_if.fill_o !== 5'd16) begin errors++; $display("FAIL partial_fill16: got %0d expected 16", u_if.fill_o); end
    checks++; if (u_if.window_o !== 8'hA5) begin errors++; $display("FAIL partial_window_a5: got %h expected a5", u_if.window_o); end
    u_if.data_i = 8'hFF; u_if.shift_vld_i = 1'b1; u_if.shift_i = 4'd3;
    #1;
    checks++; if (u_if.rdy_o !== 1'b0) begin errors++; $display("FAIL partial_rdy_full: got %b expected 0", u_if.rdy_o); end
    step();
    checks++; if (u_if.window_o !== 8'h29) begin errors++; $display("FAIL partial_window_29: got %h expected 29", u_if.window_o); end
    checks++; if (u_if.fill_o !== 5'd13) begin errors++; $display("FAIL partial_fill13: got %0d expected 13", u_if.fill_o); end
    $display("shift 3: window %h fill %0d", u_if.window_o, u_if.fill_o);
    u_if.shift_i = 4'd5;
    #1;
    checks++; if (u_if.rdy_o !== 1'b0) begin errors++; $display("FAIL partial_rdy_13: got %b expected 0", u_if.rdy_o); end
    step();
    checks++; if (u_if.window_o !== 8'h3C) begin errors++; $display("FAIL partial_window_3c: got %h expected 3c", u_if.window_o); end
    checks++; if (u_if.fill_o !== 5'd8) begin errors++; $display("FAIL partial_fill8: got %0d expected 8", u_if.fill_o); end
    u_if.shift_vld_i = 1'b0;
    #1;
    checks++; if (u_if.rdy_o !== 1'b1) begin errors++; $display("FAIL partial_rdy_8: got %b expected 1", u_if.rdy_o); end
    step();
    checks++; if (u_if.fill_o !== 5'd16) begin errors++; $display("FAIL partial_ff_fill: got %0d expected 16", u_if.fill_o); end
    $display("load ff: window %h fill %0d", u_if.window_o, u_if.fill_o);
    flush_all();
    checks++; if (u_if.fill_o !== 5'd0) begin errors++; $display("FAIL partial_flush_fill: got %0d expected 0", u_if.fill_o); end
  endtask

  task automatic test_drain();
    u_if.data_i = 8'hF0; u_if.vld_i = 1'b1; u_if.last_i = 1'b1;
    step();
    idle();
    #1;
    checks++; if (u_if.window_o !== 8'hF0) begin errors++; $display("FAIL drain_window_f0: got %h expected f0", u_if.window_o); end
    checks++; if (u_if.rdy_o !== 1'b0) begin errors++; $display("FAIL drain_rdy: got %b expected 0", u_if.rdy_o); end
    u_if.shift_vld_i = 1'b1; u_if.shift_i = 4'd4;
    step();
    checks++; if (u_if.window_o !== 8'h00) begin errors++; $display("FAIL drain_window_00: got %h expected 00", u_if.window_o); end
    checks++; if (u_if.fill_o !== 5'd4) begin errors++; $display("FAIL drain_fill4: got %0d expected 4", u_if.fill_o); end
    checks++; if (u_if.win_vld_o !== 1'b1) begin errors++; $display("FAIL drain_win_vld_4: got %b expected 1", u_if.win_vld_o); end
    $display("drain shift 4: window %h fill %0d win_vld %b", u_if.window_o, u_if.fill_o, u_if.win_vld_o);
    step();
    checks++; if (u_if.fill_o !== 5'd0) begin errors++; $display("FAIL drain_fill0: got %0d expected 0", u_if.fill_o); end
    checks++; if (u_if.win_vld_o !== 1'b0) begin errors++; $display("FAIL drain_win_vld_0: got %b expected 0", u_if.win_vld_o); end
    checks++; if (u_if.rdy_o !== 1'b1) begin errors++; $display("FAIL drain_back_to_run: got rdy %b expected 1", u_if.rdy_o); end
    idle();
  endtask

  task automatic test_over_consume();
    logic exp_err;
`ifdef EBPC_UNPACK_ERR_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    u_if.data_i = 8'hA7; u_if.vld_i = 1'b1; u_if.last_i = 1'b1;
    step();
    idle();
    u_if.shift_vld_i = 1'b1; u_if.shift_i = 4'd5;
    step();
    checks++; if (u_if.fill_o !== 5'd3) begin errors++; $display("FAIL over_fill3: got %0d expected 3", u_if.fill_o); end
    checks++; if (u_if.window_o !== 8'hE0) begin errors++; $display("FAIL over_window_e0: got %h expected e0", u_if.window_o); end
    step();
    checks++; if (u_if.fill_o !== 5'd0) begin errors++; $display("FAIL over_clamp: got %0d expected 0", u_if.fill_o); end
    checks++; if (u_if.window_o !== 8'h00) begin errors++; $display("FAIL over_window_clear: got %h expected 00", u_if.window_o); end
    checks++; if (u_if.err_o !== exp_err) begin errors++; $display("FAIL over_err: got %b expected %b", u_if.err_o, exp_err); end
    checks++; if (u_if.rdy_o !== 1'b1) begin errors++; $display("FAIL over_rdy: got %b expected 1", u_if.rdy_o); end
    flush_all();
    checks++; if (u_if.err_o !== exp_err) begin errors++; $display("FAIL over_err_after_flush: got %b expected %b", u_if.err_o, exp_err); end
    $display("over-consume: fill %0d err %b", u_if.fill_o, u_if.err_o);
  endtask

  task automatic test_ignored_shift();
    u_if.data_i = 8'hA5; u_if.vld_i = 1'b1;
    step();
    idle();
    u_if.shift_vld_i = 1'b1; u_if.shift_i = 4'd4;
    step();
    checks++; if (u_if.window_o !== 8'h50) begin errors++; $display("FAIL ignore_window_50: got %h expected 50", u_if.window_o); end
    checks++; if (u_if.win_vld_o !== 1'b0) begin errors++; $display("FAIL ignore_win_vld: got %b expected 0", u_if.win_vld_o); end
    u_if.shift_i = 4'd3;
    step();
    checks++; if (u_if.fill_o !== 5'd4) begin errors++; $display("FAIL ignore_fill4: got %0d expected 4", u_if.fill_o); end
    checks++; if (u_if.window_o !== 8'h50) begin errors++; $display("FAIL ignore_window_hold: got %h expected 50", u_if.window_o); end
    flush_all();
  endtask

  task automatic test_flush();
    u_if.data_i = 8'hA5; u_if.vld_i = 1'b1;
    step();
    u_if.data_i = 8'h3C;
    step();
    u_if.vld_i = 1'b0; u_if.shift_vld_i = 1'b1; u_if.shift_i = 4'd4;
    step();
    checks++; if (u_if.fill_o !== 5'd12) begin errors++; $display("FAIL flush_fill12: got %0d expected 12", u_if.fill_o); end
    u_if.flush_i = 1'b1; u_if.vld_i = 1'b1; u_if.data_i = 8'hFF; u_if.shift_i = 4'd2;
    #1;
    checks++; if (u_if.rdy_o !== 1'b0) begin errors++; $display("FAIL flush_rdy: got %b expected 0", u_if.rdy_o); end
    step();
    u_if.flush_i = 1'b0; u_if.shift_vld_i = 1'b0; u_if.data_i = 8'h5A;
    #1;
    checks++; if (u_if.fill_o !== 5'd0) begin errors++; $display("FAIL flush_fill0: got %0d expected 0", u_if.fill_o); end
    checks++; if (u_if.window_o !== 8'h00) begin errors++; $display("FAIL flush_window: got %h expected 00", u_if.window_o); end
    checks++; if (u_if.rdy_o !== 1'b1) begin errors++; $display("FAIL flush_rdy_next: got %b expected 1", u_if.rdy_o); end
    step();
    idle();
    checks++; if (u_if.window_o !== 8'h5A) begin errors++; $display("FAIL flush_reload: got %h expected 5a", u_if.window_o); end
    $display("flush then load 5a: window %h fill %0d", u_if.window_o, u_if.fill_o);
    flush_all();
  endtask

  task automatic test_async_reset();
    u_if.data_i = 8'hC3; u_if.vld_i = 1'b1;
    step();
    idle();
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (u_if.fill_o !== 5'd0) begin errors++; $display("FAIL async_rst_fill: got %0d expected 0", u_if.fill_o); end
    checks++; if (u_if.window_o !== 8'h00) begin errors++; $display("FAIL async_rst_window: got %h expected 00", u_if.window_o); end
    checks++; if (u_if.win_vld_o !== 1'b0) begin errors++; $display("FAIL async_rst_win_vld: got %b expected 0", u_if.win_vld_o); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_random();
    bit         mq[$];
    logic [7:0] w;
    logic [7:0] exp_win;
    bit         m_rdy, m_wv, v, sv;
    int         sh;
    for (int c = 0; c < 400; c++) begin
      m_rdy = (mq.size() <= 8);
      m_wv  = (mq.size() >= 8);
      v     = ($urandom_range(0, 9) < 6);
      sv    = ($urandom_range(0, 9) < 7);
      w     = 8'($urandom());
      sh    = $urandom_range(0, 8);
      u_if.data_i = w; u_if.vld_i = v;
      u_if.shift_vld_i = sv; u_if.shift_i = 4'(sh);
      #1;
      checks++; if (u_if.rdy_o !== m_rdy) begin errors++; $display("FAIL rand_rdy cycle %0d: got %b expected %b", c, u_if.rdy_o, m_rdy); end
      if (sv && m_wv) repeat (sh) void'(mq.pop_front());
      if (v && m_rdy) begin
        for (int b = 7; b >= 0; b--) mq.push_back(w[b]);
        $display("rand cycle %0d: word %h accepted", c, w);
      end
      step();
      exp_win = 8'h00;
      for (int b = 0; b < 8; b++) if (b < mq.size()) exp_win[7-b] = mq[b];
      checks++; if (u_if.window_o !== exp_win) begin errors++; $display("FAIL rand_window cycle %0d: got %h expected %h", c, u_if.window_o, exp_win); end
      checks++; if (u_if.fill_o !== 5'(mq.size())) begin errors++; $display("FAIL rand_fill cycle %0d: got %0d expected %0d", c, u_if.fill_o, mq.size()); end
      checks++; if (u_if.win_vld_o !== (mq.size() >= 8)) begin errors++; $display("FAIL rand_win_vld cycle %0d: got %b expected %b", c, u_if.win_vld_o, (mq.size() >= 8)); end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_shift8();
    test_partial_shift();
    test_drain();
    test_over_consume();
    test_ignored_shift();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
